// File: rtl/key_event_dev.sv
// Memory-mapped 4-key input device: 2-flop synchronisers, per-key debounce counters,
// KDATA/KCTRL registers on a shared tri-state bus, and a level interrupt.
module key_event_dev #(
  parameter logic [31:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [31:0] ADDR_KCTRL      = 32'hF0000110,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_BITS        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ABUS,
  inout  logic [31:0] DBUS,
  input  logic        we,
  input  logic [3:0]  KEY,
  output logic        intr
);

  localparam logic [CNT_BITS-1:0] CntLast = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          keySync1;
  logic [3:0]          keySync2;
  logic [3:0]          debKeys;
  logic [3:0]          debKeysNext;
  logic [CNT_BITS-1:0] debCnt     [4];
  logic [CNT_BITS-1:0] debCntNext [4];

  logic ready;
  logic readyNext;
  logic overrun;
  logic overrunNext;
  logic intEn;
  logic intEnNext;

  logic        hitKdata;
  logic        hitKctrl;
  logic        kdataRead;
  logic        kctrlWrite;
  logic        debChange;
  logic [31:0] kdataVal;
  logic [31:0] kctrlVal;

  // A counter only runs while the synchronised level disagrees with the accepted one;
  // the edge on which it already holds CntLast is the DEBOUNCE_CYCLES-th stable cycle.
  always_comb begin
    debKeysNext = debKeys;
    for (int unsigned i = 0; i < 4; i++) begin
      debCntNext[i] = '0;
      if (keySync2[i] != debKeys[i]) begin
        if (debCnt[i] == CntLast) begin
          debKeysNext[i] = keySync2[i];
        end else begin
          debCntNext[i] = debCnt[i] + CNT_BITS'(1);
        end
      end
    end
  end

  assign hitKdata   = (ABUS == ADDR_KDATA);
  assign hitKctrl   = (ABUS == ADDR_KCTRL);
  assign kdataRead  = hitKdata && !we;
  assign kctrlWrite = hitKctrl && we;
  assign debChange  = (debKeysNext != debKeys);

  assign kdataVal = {28'b0, debKeys};
  assign kctrlVal = {23'b0, intEn, 5'b0, overrun, 1'b0, ready};

  // A new debounced value always wins over a clear from a read or a write.
  always_comb begin
    readyNext   = ready;
    overrunNext = overrun;
    intEnNext   = intEn;
    if (kctrlWrite) begin
      intEnNext = DBUS[8];
      if (!DBUS[0]) readyNext = 1'b0;
      if (!DBUS[2]) overrunNext = 1'b0;
    end
    if (kdataRead) begin
      readyNext = 1'b0;
    end
    if (debChange) begin
      readyNext = 1'b1;
      if (ready && !kdataRead) overrunNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keySync1 <= '0;
      keySync2 <= '0;
      debKeys  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        debCnt[i] <= '0;
      end
      ready    <= 1'b0;
      overrun  <= 1'b0;
      intEn    <= 1'b0;
    end else begin
      keySync1 <= KEY;
      keySync2 <= keySync1;
      debKeys  <= debKeysNext;
      for (int unsigned i = 0; i < 4; i++) begin
        debCnt[i] <= debCntNext[i];
      end
      ready    <= readyNext;
      overrun  <= overrunNext;
      intEn    <= intEnNext;
    end
  end

  assign DBUS = (!we && hitKdata) ? kdataVal :
                (!we && hitKctrl) ? kctrlVal : 'z;

  assign intr = ready & intEn;

endmodule

// File: tb/tb_key_event_dev.sv
// Directed bench for key_event_dev with a short debounce window (4 cycles).
module tb_key_event_dev;

  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] KCTRL = 32'hF0000110;
  localparam logic [31:0] OTHER = 32'hF0000004;
  localparam logic [31:0] IDLE  = 32'h00000000;
  localparam logic [31:0] HIZ   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        tbOe = 1'b0;
  logic [31:0] abus = IDLE;
  logic [31:0] tbDrive = '0;
  logic [3:0]  key = 4'h0;
  logic        intr;
  tri1  [31:0] dbus;

  int checkCount = 0;
  int failCount  = 0;

  assign dbus = tbOe ? tbDrive : 'z;

  key_event_dev #(
    .ADDR_KDATA(KDATA),
    .ADDR_KCTRL(KCTRL),
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ABUS(abus),
    .DBUS(dbus),
    .we(we),
    .KEY(key),
    .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Combinational look at a register inside the low clock phase; no edge sees the address.
  task automatic peek(input logic [31:0] addr, output logic [31:0] val);
    abus = addr;
    we   = 1'b0;
    #1;
    val  = dbus;
    abus = IDLE;
  endtask

  task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] val;
    peek(addr, val);
    checkVal(tag, val, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    abus    = addr;
    we      = 1'b1;
    tbDrive = data;
    tbOe    = 1'b1;
    @(negedge clk);
    tbOe = 1'b0;
    we   = 1'b0;
    abus = IDLE;
  endtask

  task automatic busRead(input logic [31:0] addr);
    abus = addr;
    we   = 1'b0;
    @(negedge clk);
    abus = IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] val;

    cycles(2);
    checkReg("rst_kdata", KDATA, 32'h0);
    checkReg("rst_kctrl", KCTRL, 32'h0);
    checkVal("rst_intr", 32'(intr), 32'h0);
    rst = 1'b1;
    cycles(2);

    // press timing: visible exactly 6 edges after the key change
    key = 4'b0001;
    cycles(5);
    checkReg("lat5_kdata", KDATA, 32'h0);
    checkReg("lat5_kctrl", KCTRL, 32'h0);
    cycles(1);
    checkReg("lat6_kdata", KDATA, 32'h1);
    checkReg("lat6_kctrl", KCTRL, 32'h1);
    checkVal("lat6_intr", 32'(intr), 32'h0);
    busRead(KDATA);
    checkReg("rd_clr_kctrl", KCTRL, 32'h0);

    key = 4'b0000;
    cycles(6);
    checkReg("rel_kdata", KDATA, 32'h0);
    checkReg("rel_kctrl", KCTRL, 32'h1);
    busWrite(KCTRL, 32'h0);
    checkReg("wr_clr_kctrl", KCTRL, 32'h0);

    // 3-cycle glitch must not register
    key = 4'b0100;
    cycles(3);
    key = 4'b0000;
    cycles(10);
    checkReg("glitch_kdata", KDATA, 32'h0);
    checkReg("glitch_kctrl", KCTRL, 32'h0);

    // interrupt enable
    busWrite(KCTRL, 32'h100);
    checkReg("ie_kctrl", KCTRL, 32'h100);
    checkVal("ie_intr0", 32'(intr), 32'h0);
    key = 4'b0010;
    cycles(6);
    checkVal("ie_intr1", 32'(intr), 32'h1);
    checkReg("ie_kdata", KDATA, 32'h2);
    busRead(KDATA);
    checkReg("ie_rd_kctrl", KCTRL, 32'h100);
    checkVal("ie_intr_clr", 32'(intr), 32'h0);

    // two changes without a read -> overrun
    key = 4'b0000;
    cycles(6);
    key = 4'b1000;
    cycles(6);
    checkReg("ovr_kctrl", KCTRL, 32'h105);
    checkReg("ovr_kdata", KDATA, 32'h8);
    busWrite(KCTRL, 32'h100);
    checkReg("w100_kctrl", KCTRL, 32'h100);
    busWrite(KCTRL, 32'h105);
    checkReg("w105_noset", KCTRL, 32'h100);

    // change coinciding with a KDATA read keeps Ready, no overrun
    key = 4'b0000;
    cycles(6);
    checkReg("ready_again", KCTRL, 32'h101);
    key = 4'b0001;
    cycles(5);
    busRead(KDATA);
    checkReg("rdcoinc_kctrl", KCTRL, 32'h101);
    checkReg("rdcoinc_kdata", KDATA, 32'h1);

    // overrun set beats a coinciding clear
    key = 4'b0000;
    cycles(6);
    checkReg("ovr2_kctrl", KCTRL, 32'h105);
    key = 4'b0010;
    cycles(5);
    busWrite(KCTRL, 32'h101);
    checkReg("setwins_kctrl", KCTRL, 32'h105);
    busWrite(KCTRL, 32'h001);
    checkReg("ie_off_kctrl", KCTRL, 32'h001);
    checkVal("ie_off_intr", 32'(intr), 32'h0);

    // bus drive rules and ignored accesses
    checkReg("hiz_other", OTHER, HIZ);
    abus = KDATA;
    we   = 1'b1;
    #1;
    checkVal("hiz_we1", dbus, HIZ);
    tbDrive = 32'h0;
    tbOe    = 1'b1;
    @(negedge clk);
    tbOe = 1'b0;
    we   = 1'b0;
    abus = IDLE;
    checkReg("kdwr_kdata", KDATA, 32'h2);
    checkReg("kdwr_kctrl", KCTRL, 32'h001);
    busWrite(OTHER, 32'h0);
    busRead(OTHER);
    checkReg("other_kctrl", KCTRL, 32'h001);

    // asynchronous reset mid-count
    key = 4'hF;
    cycles(3);
    rst = 1'b0;
    #1;
    checkVal("arst_intr", 32'(intr), 32'h0);
    checkReg("arst_kdata", KDATA, 32'h0);
    checkReg("arst_kctrl", KCTRL, 32'h0);
    cycles(2);
    rst = 1'b1;
    cycles(5);
    checkReg("post5_kdata", KDATA, 32'h0);
    cycles(1);
    checkReg("post6_kdata", KDATA, 32'hF);
    checkReg("post6_kctrl", KCTRL, 32'h001);
    peek(IDLE, val);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
